// File: rtl/memory_controller_if.sv
// Bundle of the byte-wide RAM port plus the LSU and icache request/return channels.
// The controller takes the slave modport; requesters and RAM sit on the master side.
interface memory_controller_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;
   logic              io_buffer_full;

   logic              lsu2memCon_enable;
   logic              lsu2memCon_rw;
   logic [1:0]        lsu2memCon_width;
   logic [ADDR_W-1:0] lsu2memCon_addr;
   logic [31:0]       lsu2memCon_data;
   logic              memCon2lsu_enable;
   logic [31:0]       memCon2lsu_return;

   logic              icache2memCon_enable;
   logic [ADDR_W-1:0] icache2memCon_addr;
   logic              memCon2icache_enable;
   logic [31:0]       memCon2icache_inst;

   modport slave (
      input  mem_din, io_buffer_full,
      input  lsu2memCon_enable, lsu2memCon_rw, lsu2memCon_width, lsu2memCon_addr, lsu2memCon_data,
      input  icache2memCon_enable, icache2memCon_addr,
      output mem_dout, mem_a, mem_wr,
      output memCon2lsu_enable, memCon2lsu_return,
      output memCon2icache_enable, memCon2icache_inst
   );

   modport master (
      output mem_din, io_buffer_full,
      output lsu2memCon_enable, lsu2memCon_rw, lsu2memCon_width, lsu2memCon_addr, lsu2memCon_data,
      output icache2memCon_enable, icache2memCon_addr,
      input  mem_dout, mem_a, mem_wr,
      input  memCon2lsu_enable, memCon2lsu_return,
      input  memCon2icache_enable, memCon2icache_inst
   );
endinterface

// File: rtl/memory_controller.sv
// Sequences one LSU access or icache fetch at a time into per-byte RAM cycles,
// assembling read bytes little-endian and returning them with a one-cycle done pulse.
module memory_controller #(
   parameter int unsigned ADDR_W = 32,
   parameter logic [1:0]  IO_SEL = 2'b11
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic rdy_in,
   input  logic rob2memCon_clear,
   memory_controller_if.slave bus
);
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;    // 1 = icache owns the access
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [1:0]        rd_sel;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       buf_q, buf_d;
   logic [31:0]       lsu_ret_q, lsu_ret_d;
   logic [31:0]       ic_inst_q, ic_inst_d;
   logic [7:0]        dout_q, dout_d;
   logic              wr_q, wr_d;
   logic              lsu_done_q, lsu_done_d;
   logic              ic_done_q, ic_done_d;
   logic              stall_c;

   // A store into a full IO buffer holds its pending byte until the buffer drains.
   assign stall_c = (state_q == WRITE) && (base_q[17:16] == IO_SEL) && bus.io_buffer_full;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      base_d     = base_q;
      mem_a_d    = mem_a_q;
      data_d     = data_q;
      buf_d      = buf_q;
      lsu_ret_d  = lsu_ret_q;
      ic_inst_d  = ic_inst_q;
      dout_d     = dout_q;
      wr_d       = wr_q;
      lsu_done_d = 1'b0;
      ic_done_d  = 1'b0;
      cnt_inc    = cnt_q + CNT_W'(1);
      rd_sel     = 2'(cnt_q - CNT_W'(1));

      case (state_q)
         IDLE: begin
            if (!rob2memCon_clear && (bus.lsu2memCon_enable || bus.icache2memCon_enable)) begin
               cnt_d = '0;
               buf_d = '0;
               if (bus.lsu2memCon_enable) begin
                  owner_d = 1'b0;
                  base_d  = bus.lsu2memCon_addr;
                  data_d  = bus.lsu2memCon_data;
                  wr_d    = bus.lsu2memCon_rw;
                  state_d = bus.lsu2memCon_rw ? WRITE : READ;
                  case (bus.lsu2memCon_width)
                     2'd0:    n_d = CNT_W'(1);
                     2'd1:    n_d = CNT_W'(2);
                     default: n_d = CNT_W'(4);
                  endcase
               end else begin
                  owner_d = 1'b1;
                  base_d  = bus.icache2memCon_addr;
                  data_d  = '0;
                  wr_d    = 1'b0;
                  n_d     = CNT_W'(4);
                  state_d = READ;
               end
               mem_a_d = base_d;
               dout_d  = data_d[7:0];
            end
         end
         // Byte k is addressed at cnt==k and its data arrives one cycle later.
         READ: begin
            if (rob2memCon_clear) begin
               state_d = IDLE;
            end else begin
               if (cnt_q != '0) buf_d = buf_q | (32'(bus.mem_din) << {rd_sel, 3'b000});
               if (cnt_q == n_q) begin
                  state_d = DONE;
                  if (owner_q) begin
                     ic_done_d = 1'b1;
                     ic_inst_d = buf_d;
                  end else begin
                     lsu_done_d = 1'b1;
                     lsu_ret_d  = buf_d;
                  end
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc < n_q) mem_a_d = base_q + ADDR_W'(cnt_inc);
               end
            end
         end
         WRITE: begin
            if (!stall_c) begin
               if (cnt_inc == n_q) begin
                  state_d = DONE;
                  wr_d    = 1'b0;
                  if (owner_q) ic_done_d = 1'b1;
                  else         lsu_done_d = 1'b1;
               end else begin
                  cnt_d   = cnt_inc;
                  mem_a_d = base_q + ADDR_W'(cnt_inc);
                  dout_d  = 8'(data_q >> {cnt_inc[1:0], 3'b000});
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         n_q        <= '0;
         cnt_q      <= '0;
         base_q     <= '0;
         mem_a_q    <= '0;
         data_q     <= '0;
         buf_q      <= '0;
         lsu_ret_q  <= '0;
         ic_inst_q  <= '0;
         dout_q     <= '0;
         wr_q       <= 1'b0;
         lsu_done_q <= 1'b0;
         ic_done_q  <= 1'b0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         mem_a_q    <= mem_a_d;
         data_q     <= data_d;
         buf_q      <= buf_d;
         lsu_ret_q  <= lsu_ret_d;
         ic_inst_q  <= ic_inst_d;
         dout_q     <= dout_d;
         wr_q       <= wr_d;
         lsu_done_q <= lsu_done_d;
         ic_done_q  <= ic_done_d;
      end
   end

   // Write strobe is masked while frozen or stalled so a held byte is never written twice.
   assign bus.mem_wr               = wr_q & rdy_in & ~stall_c;
   assign bus.mem_a                = mem_a_q;
   assign bus.mem_dout             = dout_q;
   assign bus.memCon2lsu_enable    = lsu_done_q;
   assign bus.memCon2lsu_return    = lsu_ret_q;
   assign bus.memCon2icache_enable = ic_done_q;
   assign bus.memCon2icache_inst   = ic_inst_q;
endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: directed corner cases plus random traffic
// checked against a byte-array reference memory and arithmetic latency rules.
module tb_memory_controller;
   logic clk_in = 1'b0;
   logic rst_in, rdy_in, rob2memCon_clear;

   always #5 clk_in = ~clk_in;

   memory_controller_if #(.ADDR_W(32)) bus();

   memory_controller #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .rob2memCon_clear (rob2memCon_clear),
      .bus              (bus)
   );

   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
   } exp_t;

   exp_t        q_lsu[$];
   exp_t        q_ic[$];
   logic [7:0]  ram     [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];
   int unsigned cyc = 0, n_tests = 0, n_fail = 0, n_wr = 0, n_lsu_done = 0, n_ic_done = 0;
   logic [31:0] a_lat = '0, model_lsu_ret = '0;

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : dflt(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // RAM device (read data one cycle after the address, frozen with rdy) and done monitor.
   always @(negedge clk_in) begin
      exp_t e;
      bus.mem_din = ram_rd(a_lat);
      if (rdy_in) a_lat = bus.mem_a;
      if (bus.mem_wr === 1'b1) begin
         ram[bus.mem_a] = bus.mem_dout;
         n_wr++;
      end
      if (bus.memCon2lsu_enable === 1'b1) begin
         n_lsu_done++;
         if (q_lsu.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL lsu_spurious_done: pulse at cycle %0d with nothing outstanding", cyc);
         end else begin
            e = q_lsu.pop_front();
            check("lsu_return", bus.memCon2lsu_return, e.data);
            check("lsu_done_cycle", cyc, e.cyc);
         end
      end
      if (bus.memCon2icache_enable === 1'b1) begin
         n_ic_done++;
         if (q_ic.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL ic_spurious_done: pulse at cycle %0d with nothing outstanding", cyc);
         end else begin
            e = q_ic.pop_front();
            check("ic_inst", bus.memCon2icache_inst, e.data);
            check("ic_done_cycle", cyc, e.cyc);
         end
      end
      cyc++;
   end

   // Reference: bytes land little-endian at addr+k; read done at accept+2+n, write at accept+1+n.
   function automatic void push_exp(input bit ic, input bit rw, input logic [1:0] width,
                                    input logic [31:0] addr, input logic [31:0] data,
                                    input int unsigned x0, input int unsigned extra);
      int unsigned n;
      exp_t        e;
      logic [31:0] v;
      logic [31:0] a;
      n = ic ? 4 : (width == 2'd0 ? 1 : (width == 2'd1 ? 2 : 4));
      v = '0;
      for (int k = 0; k < int'(n); k++) begin
         a = addr + 32'(k);
         if (rw) ref_mem[a] = data[8*k +: 8];
         else    v[8*k +: 8] = ref_rd(a);
      end
      if (rw) begin
         e.data = model_lsu_ret;
         e.cyc  = x0 + 1 + n + extra;
      end else begin
         e.data = v;
         e.cyc  = x0 + 2 + n + extra;
         if (!ic) model_lsu_ret = v;
      end
      if (ic) q_ic.push_back(e);
      else    q_lsu.push_back(e);
   endfunction

   function automatic void poke(input logic [31:0] a, input logic [7:0] b);
      ram[a]     = b;
      ref_mem[a] = b;
   endfunction

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 4) == 0) return 32'hFFFF_FFFE + 32'($urandom_range(0, 1));
      return 32'h1000 + 32'($urandom_range(0, 15));
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic raise(input bit ic, input bit rw, input logic [1:0] width,
                        input logic [31:0] addr, input logic [31:0] data);
      if (ic) begin
         bus.icache2memCon_addr   = addr;
         bus.icache2memCon_enable = 1'b1;
      end else begin
         bus.lsu2memCon_rw     = rw;
         bus.lsu2memCon_width  = width;
         bus.lsu2memCon_addr   = addr;
         bus.lsu2memCon_data   = data;
         bus.lsu2memCon_enable = 1'b1;
      end
   endtask

   task automatic wait_done(input bit ic);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (ic ? bus.memCon2icache_enable : bus.memCon2lsu_enable) seen = 1'b1;
      end
      if (ic) bus.icache2memCon_enable = 1'b0;
      else    bus.lsu2memCon_enable    = 1'b0;
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: no done pulse within 40 cycles", ic ? "ic" : "lsu");
      end
   endtask

   task automatic issue(input bit ic, input bit rw, input logic [1:0] width,
                        input logic [31:0] addr, input logic [31:0] data, input bit clr_first);
      int unsigned x0;
      tick();
      x0 = cyc;
      if (clr_first) begin
         rob2memCon_clear = 1'b1;
         x0 = cyc + 1;
      end
      push_exp(ic, rw, width, addr, data, x0, 0);
      raise(ic, rw, width, addr, data);
      if (clr_first) begin
         tick();
         rob2memCon_clear = 1'b0;
      end
      wait_done(ic);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_mem_a"},    bus.mem_a, 32'h0);
      check({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'h0);
      check({tag, "_mem_wr"},   32'(bus.mem_wr), 32'h0);
      check({tag, "_lsu_en"},   32'(bus.memCon2lsu_enable), 32'h0);
      check({tag, "_lsu_ret"},  bus.memCon2lsu_return, 32'h0);
      check({tag, "_ic_en"},    32'(bus.memCon2icache_enable), 32'h0);
      check({tag, "_ic_inst"},  bus.memCon2icache_inst, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned x0, w0, c0;
      rst_in = 1'b1; rdy_in = 1'b1; rob2memCon_clear = 1'b0;
      bus.io_buffer_full = 1'b0;
      bus.lsu2memCon_enable = 1'b0; bus.lsu2memCon_rw = 1'b0; bus.lsu2memCon_width = 2'd0;
      bus.lsu2memCon_addr = '0; bus.lsu2memCon_data = '0;
      bus.icache2memCon_enable = 1'b0; bus.icache2memCon_addr = '0;
      tick(); tick();
      check_outputs_zero("reset");
      rst_in = 1'b0;

      // LSU word read with observed address sequence
      poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
      tick(); x0 = cyc;
      push_exp(0, 0, 2'd2, 32'h100, '0, x0, 0);
      raise(0, 0, 2'd2, 32'h100, '0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("word_rd_mem_a", bus.mem_a, 32'h100 + 32'(i));
      end
      wait_done(0);
      check("word_rd_value", bus.memCon2lsu_return, 32'h4433_2211);

      // Simultaneous requests: LSU half write first, icache fetch right after
      tick(); x0 = cyc;
      push_exp(0, 1, 2'd1, 32'h200, 32'h0000_BEEF, x0, 0);
      push_exp(1, 0, 2'd2, 32'h0, '0, x0 + 4, 0);
      raise(0, 1, 2'd1, 32'h200, 32'h0000_BEEF);
      raise(1, 0, 2'd2, 32'h0, '0);
      wait_done(0);
      wait_done(1);
      check("half_wr_byte0", 32'(ram_rd(32'h200)), 32'hEF);
      check("half_wr_byte1", 32'(ram_rd(32'h201)), 32'hBE);

      // IO-region store held off by a full IO buffer for three cycles
      tick(); x0 = cyc; w0 = n_wr;
      push_exp(0, 1, 2'd0, 32'h3_0000, 32'h41, x0, 3);
      raise(0, 1, 2'd0, 32'h3_0000, 32'h41);
      tick(); bus.io_buffer_full = 1'b1;
      tick(); check("io_stall_wr_a", 32'(bus.mem_wr), 32'h0);
      tick(); check("io_stall_wr_b", 32'(bus.mem_wr), 32'h0);
      tick(); bus.io_buffer_full = 1'b0;
      wait_done(0);
      check("io_write_count", n_wr - w0, 32'd1);
      check("io_write_byte", 32'(ram_rd(32'h3_0000)), 32'h41);

      // Icache fetch aborted by clear in its third cycle
      tick(); c0 = n_ic_done;
      raise(1, 0, 2'd2, 32'h1004, '0);
      tick(); tick();
      rob2memCon_clear = 1'b1; bus.icache2memCon_enable = 1'b0;
      tick(); rob2memCon_clear = 1'b0;
      check("clr_mem_a_held", bus.mem_a, 32'h1005);
      repeat (6) tick();
      check("clr_no_ic_done", n_ic_done, c0);
      issue(1, 0, 2'd2, 32'h1004, '0, 0);
      issue(0, 0, 2'd2, 32'h1010, '0, 1);

      // Clear during a word store does not abort it
      tick(); x0 = cyc;
      push_exp(0, 1, 2'd2, 32'h1008, 32'hCAFE_F00D, x0, 0);
      raise(0, 1, 2'd2, 32'h1008, 32'hCAFE_F00D);
      tick(); tick(); rob2memCon_clear = 1'b1;
      tick(); rob2memCon_clear = 1'b0;
      wait_done(0);
      issue(0, 0, 2'd2, 32'h1008, '0, 0);
      check("clr_store_readback", bus.memCon2lsu_return, 32'hCAFE_F00D);

      // Two frozen cycles in the middle of a word read
      tick(); x0 = cyc;
      push_exp(0, 0, 2'd2, 32'h100, '0, x0, 2);
      raise(0, 0, 2'd2, 32'h100, '0);
      tick(); tick(); rdy_in = 1'b0;
      tick(); check("freeze_mem_a", bus.mem_a, 32'h101);
      tick(); rdy_in = 1'b1;
      wait_done(0);
      check("freeze_rd_value", bus.memCon2lsu_return, 32'h4433_2211);

      // Frozen cycle during a byte store must not strobe or double-write
      tick(); x0 = cyc; w0 = n_wr;
      push_exp(0, 1, 2'd0, 32'h1020, 32'h0000_00A5, x0, 1);
      raise(0, 1, 2'd0, 32'h1020, 32'h0000_00A5);
      tick(); rdy_in = 1'b0;
      tick(); check("freeze_mem_wr", 32'(bus.mem_wr), 32'h0);
      rdy_in = 1'b1;
      wait_done(0);
      check("freeze_write_count", n_wr - w0, 32'd1);

      // Reset in the middle of a read abandons it
      tick(); c0 = n_lsu_done;
      raise(0, 0, 2'd2, 32'h100, '0);
      tick(); tick();
      rst_in = 1'b1; bus.lsu2memCon_enable = 1'b0;
      tick(); rst_in = 1'b0;
      check_outputs_zero("midrst");
      model_lsu_ret = '0;
      repeat (6) tick();
      check("midrst_no_done", n_lsu_done, c0);

      // Random traffic against the reference memory
      for (int t = 0; t < 40; t++) begin
         bit          ic, rw;
         logic [1:0]  width;
         repeat ($urandom_range(0, 2)) tick();
         ic    = ($urandom_range(0, 3) == 0);
         rw    = ic ? 1'b0 : 1'($urandom_range(0, 1));
         width = 2'($urandom_range(0, 3));
         issue(ic, rw, width, rand_addr(), $urandom, ($urandom_range(0, 7) == 0));
      end

      repeat (4) tick();
      check("lsu_queue_drained", q_lsu.size(), 32'd0);
      check("ic_queue_drained", q_ic.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sole owner of the byte-wide external RAM/IO port, sitting directly downstream of the load-store unit and the instruction cache.
- Accepts one word/half/byte access from the LSU or one 4-byte instruction fetch from the icache at a time, and sequences it into per-byte RAM cycles.
- Assembles read bytes little-endian and returns them with a one-cycle done pulse.
- Handles IO-buffer back-pressure on stores and aborts speculative reads on pipeline clear.

Parameters:
ADDR_W, 32, byte address width of RAM port and request addresses
IO_SEL, 2'b11, value of addr[17:16] that marks the memory-mapped IO region

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; 0 freezes all state
rob2memCon_clear  input  1  pipeline flush
mem_din  input  8  RAM read byte (valid the cycle after its address)
mem_dout  output  8  RAM write byte
mem_a  output  ADDR_W  RAM byte address
mem_wr  output  1  1 = write
io_buffer_full  input  1  IO write buffer full
lsu2memCon_enable  input  1  LSU request, held until done
lsu2memCon_rw  input  1  0 = read, 1 = write
lsu2memCon_width  input  2  0 = byte, 1 = half, 2 = word (3 illegal)
lsu2memCon_addr  input  ADDR_W  start byte address
lsu2memCon_data  input  32  store data, low bytes used
memCon2lsu_enable  output  1  one-cycle done pulse
memCon2lsu_return  output  32  load data, zero-extended
icache2memCon_enable  input  1  fetch request, held until done
icache2memCon_addr  input  ADDR_W  fetch address
memCon2icache_enable  output  1  one-cycle done pulse
memCon2icache_inst  output  32  fetched instruction

Behaviour:
- Reset (sync, rst_in=1 at edge): state IDLE. All outputs 0: mem_a, mem_dout, mem_wr, both done pulses, both data returns. Byte counter and buffer cleared. Reset mid-access abandons it with no done pulse.
- rdy_in=0: no register updates. mem_wr output is gated to 0 (mem_wr = wr_q & rdy_in) so no byte is written twice.
- States: IDLE, READ, WRITE, DONE.
- IDLE, cycle T, request present, clear=0:
  - The LSU wins if both requesters are enabled.
  - Latch owner, addr, rw, n (1/2/4 bytes; icache always 4, read), and store data.
  - k=0; go to READ or WRITE.
  - Registered mem_a=addr; mem_wr=rw; mem_dout=data[7:0].
- READ:
  - Byte k address is on mem_a in cycle T+1+k (mem_a = addr+k, 32-bit wrap).
  - mem_din is sampled in cycle T+2+k into bits [8k+7:8k].
  - mem_wr is 0 throughout.
  - When the last byte is sampled (end of cycle T+1+n): load the owner's data register with the assembled value (upper bytes 0) and set the owner's done pulse, visible in cycle T+2+n. Go to DONE.
  - Word latency: request in T, done in T+6.
- WRITE:
  - Byte k is driven with mem_wr=1 in cycle T+1+k.
  - After the last byte (cycle T+n), done is visible in cycle T+1+n; go to DONE.
  - IO stall: if addr[17:16]==IO_SEL and io_buffer_full=1, the pending byte is not issued (mem_wr=0), k holds, and the byte is retried each cycle until io_buffer_full=0.
- DONE: lasts exactly 1 cycle, the done-pulse cycle. All requests are ignored, then return to IDLE. Requesters must drop or replace enable by the following cycle.
- Done pulses and data registers:
  - Done pulses are high for exactly 1 cycle.
  - Data registers hold their value until the next done for the same owner.
- rob2memCon_clear=1:
  - Any READ (icache or LSU) returns to IDLE next cycle with no done pulse and mem_a unchanged.
  - An in-progress WRITE ignores clear and completes with its done pulse (the store is committed).
  - In IDLE, requests in the clear cycle are ignored.
- width=3: treated as word.

Test Plan:
- Reset then LSU word read at 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in T+1..T+4, memCon2lsu_enable one cycle at T+6, return 0x44332211.
- LSU and icache both enabled in the same IDLE cycle (LSU half write 0xBEEF at 0x200, icache fetch 0x0) -> bytes EF,BE written at 0x200/0x201 with mem_wr=1, LSU done; icache served next, done 6 cycles after its accept.
- LSU byte write 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then 1 write, done the cycle after.
- Icache fetch with clear asserted in its 3rd cycle -> no memCon2icache_enable; next request accepted from IDLE normally. Clear during an LSU word write -> all 4 bytes written, done pulses.
- rdy_in=0 for 2 cycles mid word read -> mem_wr 0, state frozen, result still 0x44332211 with done delayed by 2 cycles. Reset asserted mid-read -> all outputs 0, no done.
